// File: rtl/cpu_batch_driver_pkg.sv
// Shared definitions for the batch-compute driver: state encoding, default
// core geometry shared with the compute core, and an index-width helper.
package cpu_batch_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUT  = 2'd1,
        ST_GET  = 2'd2,
        ST_DONE = 2'd3
    } drv_state_t;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_BATCH   = 6;
    localparam int DEF_OFFSET  = 10;
    localparam int DEF_TIMEOUT = 255;

    // Width of an index that counts 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cpu_batch_driver_wait_timer.sv
// Consecutive-idle-cycle counter shared by the PUT and GET phases.
// o_tc flags the stall cycle on which the count would reach TIMEOUT.
module cpu_drv_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    assign o_tc = i_inc && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_tc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cpu_batch_driver.sv
// Initiator for the batch-compute core: puts BATCH words, drains BATCH results
// and checks them. Define CPU_DRV_FIRST_ERR_EN to expose first-mismatch capture.
module cpu_batch_driver
    import cpu_batch_driver_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int BATCH   = DEF_BATCH,
    parameter int OFFSET  = DEF_OFFSET,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [WIDTH-1:0]             base,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout,
    output logic [$clog2(BATCH+1)-1:0]   err_cnt,
    output logic [WIDTH-1:0]             put_datas,
    output logic                         EN_put,
    input  logic                         RDY_put,
    input  logic [WIDTH-1:0]             get,
    output logic                         EN_get,
    input  logic                         RDY_get
`ifdef CPU_DRV_FIRST_ERR_EN
    ,
    output logic [idx_width(BATCH)-1:0]  first_err_idx,
    output logic [WIDTH-1:0]             first_err_data
`endif
);

    localparam int IW = idx_width(BATCH);
    localparam int EW = $clog2(BATCH + 1);

    drv_state_t       r_state;
    drv_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_base;
    logic [IW-1:0]    r_idx;
    logic [EW-1:0]    r_err;
    logic             r_timeout;
    logic             r_pass;

    logic             w_launch;
    logic             w_put_xfer;
    logic             w_get_xfer;
    logic             w_xfer;
    logic             w_wait_inc;
    logic             w_tc;
    logic             w_to;
    logic             w_last;
    logic             w_mismatch;
    logic [WIDTH-1:0] w_expect;
    logic [EW-1:0]    w_err_nxt;

    assign busy      = (r_state == ST_PUT) || (r_state == ST_GET);
    assign done      = (r_state == ST_DONE);
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign err_cnt   = r_err;

    assign put_datas = r_base + WIDTH'(r_idx);
    assign w_expect  = r_base + WIDTH'(r_idx) + WIDTH'(OFFSET);
    assign w_last    = (r_idx == IW'(BATCH - 1));

    // Handshake terms kept outside the FSM block so the timer's terminal flag
    // can feed next-state logic without a block-level combinational loop.
    assign w_put_xfer = (r_state == ST_PUT) && RDY_put;
    assign w_get_xfer = (r_state == ST_GET) && RDY_get;
    assign w_xfer     = w_put_xfer || w_get_xfer;
    assign w_wait_inc = ((r_state == ST_PUT) && !RDY_put) ||
                        ((r_state == ST_GET) && !RDY_get);
    assign w_launch   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
    assign w_to       = w_tc;
    assign EN_put     = w_put_xfer;
    assign EN_get     = w_get_xfer;

    assign w_mismatch = w_get_xfer && (get != w_expect);
    assign w_err_nxt  = (w_mismatch && (r_err != EW'(BATCH))) ? r_err + EW'(1) : r_err;

    cpu_drv_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk   (clk),
        .rst_n (reset),
        .i_clr (w_launch || w_xfer),
        .i_inc (w_wait_inc),
        .o_tc  (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_state_nxt = ST_PUT;
            end
            ST_PUT: begin
                if (w_put_xfer && w_last) w_state_nxt = ST_GET;
                else if (w_tc)            w_state_nxt = ST_DONE;
            end
            ST_GET: begin
                if (w_get_xfer && w_last) w_state_nxt = ST_DONE;
                else if (w_tc)            w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_base    <= '0;
            r_idx     <= '0;
            r_err     <= '0;
            r_timeout <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) begin
                r_base    <= base;
                r_idx     <= '0;
                r_err     <= '0;
                r_timeout <= 1'b0;
                r_pass    <= 1'b0;
            end else begin
                if (w_xfer) r_idx <= w_last ? '0 : r_idx + IW'(1);
                r_err <= w_err_nxt;
                if (w_to) r_timeout <= 1'b1;
                // Status is frozen on the entry into DONE, including the last result.
                if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE))
                    r_pass <= !w_to && (w_err_nxt == '0);
            end
        end
    end

`ifdef CPU_DRV_FIRST_ERR_EN
    logic [IW-1:0]    r_first_idx;
    logic [WIDTH-1:0] r_first_data;

    assign first_err_idx  = r_first_idx;
    assign first_err_data = r_first_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_first_idx  <= '0;
            r_first_data <= '0;
        end else if (w_launch) begin
            r_first_idx  <= '0;
            r_first_data <= '0;
        end else if (w_mismatch && (r_err == '0)) begin
            r_first_idx  <= r_idx;
            r_first_data <= get;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_batch_driver.sv
// Directed self-checking bench for cpu_batch_driver; the bench plays the
// compute core (RDY_put/RDY_get/get) and logs every put transfer.
module tb_cpu_batch_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [2:0]  err_cnt;
    logic [31:0] put_datas;
    logic        EN_put;
    logic        RDY_put;
    logic [31:0] get;
    logic        EN_get;
    logic        RDY_get;
`ifdef CPU_DRV_FIRST_ERR_EN
    logic [2:0]  first_err_idx;
    logic [31:0] first_err_data;
`endif

    cpu_batch_driver #(
        .WIDTH   (32),
        .BATCH   (6),
        .OFFSET  (10),
        .TIMEOUT (255)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .err_cnt   (err_cnt),
        .put_datas (put_datas),
        .EN_put    (EN_put),
        .RDY_put   (RDY_put),
        .get       (get),
        .EN_get    (EN_get),
        .RDY_get   (RDY_get)
`ifdef CPU_DRV_FIRST_ERR_EN
        ,
        .first_err_idx  (first_err_idx),
        .first_err_data (first_err_data)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int          gidx = 0;
    int          bad_idx = -1;
    logic [31:0] bad_val = 32'h0;
    int          stall_after = -1;
    int          stall_len = 0;

    logic [31:0] put_log [0:15];
    int          put_n = 0;
    int          en_get_n = 0;
    int          en_put_viol = 0;
    int          overlap = 0;

    // Core model: correct result is base + index + 10 unless a word is forced bad.
    always_comb begin
        if (gidx == bad_idx) get = bad_val;
        else                 get = base + 32'(gidx) + 32'd10;
    end

    always @(posedge clk) begin
        if (start)                 gidx <= 0;
        else if (EN_get && RDY_get) gidx <= gidx + 1;
    end

    always @(negedge clk) begin
        if (start) begin
            put_n       <= 0;
            en_get_n    <= 0;
            en_put_viol <= 0;
            overlap     <= 0;
        end else begin
            if (EN_put && RDY_put && put_n < 16) begin
                put_log[put_n] <= put_datas;
                put_n          <= put_n + 1;
            end
            if (EN_get)            en_get_n    <= en_get_n + 1;
            if (EN_put && !RDY_put) en_put_viol <= en_put_viol + 1;
            if (EN_put && EN_get)   overlap     <= overlap + 1;
        end
    end

    // Pulses start with base b, then steps cycles until done (cycles=-1 if never).
    task automatic run_batch(input logic [31:0] b, input int budget,
                             output int cycles, output logic first_en, output logic done_c1);
        int stall_cnt;
        stall_cnt = 0;
        cycles    = -1;
        first_en  = 1'b0;
        done_c1   = 1'b1;
        @(posedge clk); #1;
        base    = b;
        start   = 1'b1;
        RDY_put = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (put_n == stall_after && stall_cnt < stall_len) begin
                RDY_put = 1'b0;
                stall_cnt++;
            end else begin
                RDY_put = 1'b1;
            end
            #1;
            if (c == 1) begin
                first_en = EN_put;
                done_c1  = done;
            end
            if (done) begin
                cycles = c;
                break;
            end
        end
        RDY_put = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; base = '0; RDY_put = 1'b1; RDY_get = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (pass !== 1'b0)        begin bad++; $display("FAIL reset_pass got=%b exp=0", pass); end
        total++; if (timeout !== 1'b0)     begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        total++; if (err_cnt !== 3'd0)     begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        total++; if (put_datas !== 32'h0)  begin bad++; $display("FAIL reset_put_datas got=%h exp=0", put_datas); end
        total++; if (EN_put !== 1'b0)      begin bad++; $display("FAIL reset_en_put got=%b exp=0", EN_put); end
        total++; if (EN_get !== 1'b0)      begin bad++; $display("FAIL reset_en_get got=%b exp=0", EN_get); end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", busy, done); end
    endtask

    task automatic test_normal();
        int cyc; logic fe; logic d1;
        run_batch(32'h100, 100, cyc, fe, d1);
        total++; if (fe !== 1'b1)      begin bad++; $display("FAIL normal_first_en_put got=%b exp=1", fe); end
        total++; if (cyc != 13)        begin bad++; $display("FAIL normal_latency got=%0d exp=13", cyc); end
        total++; if (pass !== 1'b1)    begin bad++; $display("FAIL normal_pass got=%b exp=1", pass); end
        total++; if (err_cnt !== 3'd0) begin bad++; $display("FAIL normal_err_cnt got=%0d exp=0", err_cnt); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL normal_timeout got=%b exp=0", timeout); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL normal_busy_at_done got=%b exp=0", busy); end
        total++; if (put_n != 6)       begin bad++; $display("FAIL normal_put_count got=%0d exp=6", put_n); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (put_log[i] !== 32'h100 + 32'(i)) begin
                bad++; $display("FAIL normal_put_word[%0d] got=%h exp=%h", i, put_log[i], 32'h100 + 32'(i));
            end
        end
        total++; if (en_get_n != 6)    begin bad++; $display("FAIL normal_get_count got=%0d exp=6", en_get_n); end
        total++; if (overlap != 0)     begin bad++; $display("FAIL normal_en_overlap got=%0d exp=0", overlap); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (done !== 1'b1 || pass !== 1'b1) begin bad++; $display("FAIL normal_done_hold done=%b pass=%b exp=1/1", done, pass); end
    endtask

    task automatic test_mismatch();
        int cyc; logic fe; logic d1;
        bad_idx = 3; bad_val = 32'hDEAD;
        run_batch(32'h200, 100, cyc, fe, d1);
        bad_idx = -1;
        total++; if (cyc != 13)        begin bad++; $display("FAIL mismatch_latency got=%0d exp=13", cyc); end
        total++; if (err_cnt !== 3'd1) begin bad++; $display("FAIL mismatch_err_cnt got=%0d exp=1", err_cnt); end
        total++; if (pass !== 1'b0)    begin bad++; $display("FAIL mismatch_pass got=%b exp=0", pass); end
`ifdef CPU_DRV_FIRST_ERR_EN
        total++; if (first_err_idx !== 3'd3)       begin bad++; $display("FAIL mismatch_first_idx got=%0d exp=3", first_err_idx); end
        total++; if (first_err_data !== 32'hDEAD)  begin bad++; $display("FAIL mismatch_first_data got=%h exp=0000dead", first_err_data); end
`endif
    endtask

    task automatic test_back_to_back();
        int cyc; logic fe; logic d1;
        run_batch(32'h300, 100, cyc, fe, d1);
        total++; if (d1 !== 1'b0)      begin bad++; $display("FAIL b2b_done_drop got=%b exp=0", d1); end
        total++; if (fe !== 1'b1)      begin bad++; $display("FAIL b2b_first_en_put got=%b exp=1", fe); end
        total++; if (cyc != 13)        begin bad++; $display("FAIL b2b_latency got=%0d exp=13", cyc); end
        total++; if (err_cnt !== 3'd0) begin bad++; $display("FAIL b2b_err_cnt got=%0d exp=0", err_cnt); end
        total++; if (pass !== 1'b1)    begin bad++; $display("FAIL b2b_pass got=%b exp=1", pass); end
`ifdef CPU_DRV_FIRST_ERR_EN
        total++; if (first_err_idx !== 3'd0 || first_err_data !== 32'h0) begin
            bad++; $display("FAIL b2b_first_err_clear idx=%0d data=%h exp=0/0", first_err_idx, first_err_data);
        end
`endif
    endtask

    task automatic test_backpressure();
        int cyc; logic fe; logic d1;
        stall_after = 3; stall_len = 4;
        run_batch(32'h100, 100, cyc, fe, d1);
        stall_after = -1; stall_len = 0;
        total++; if (cyc != 17)        begin bad++; $display("FAIL bp_latency got=%0d exp=17", cyc); end
        total++; if (en_put_viol != 0) begin bad++; $display("FAIL bp_en_put_in_stall got=%0d exp=0", en_put_viol); end
        total++; if (put_n != 6)       begin bad++; $display("FAIL bp_put_count got=%0d exp=6", put_n); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (put_log[i] !== 32'h100 + 32'(i)) begin
                bad++; $display("FAIL bp_put_word[%0d] got=%h exp=%h", i, put_log[i], 32'h100 + 32'(i));
            end
        end
        total++; if (pass !== 1'b1)    begin bad++; $display("FAIL bp_pass got=%b exp=1", pass); end
    endtask

    task automatic test_wrap();
        int cyc; logic fe; logic d1;
        logic [31:0] exp_w [0:5];
        exp_w = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2, 32'h3};
        run_batch(32'hFFFF_FFFE, 100, cyc, fe, d1);
        total++; if (put_n != 6)       begin bad++; $display("FAIL wrap_put_count got=%0d exp=6", put_n); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (put_log[i] !== exp_w[i]) begin
                bad++; $display("FAIL wrap_put_word[%0d] got=%h exp=%h", i, put_log[i], exp_w[i]);
            end
        end
        total++; if (pass !== 1'b1 || err_cnt !== 3'd0) begin bad++; $display("FAIL wrap_pass pass=%b err=%0d exp=1/0", pass, err_cnt); end
    endtask

    task automatic test_timeout();
        int cyc; logic fe; logic d1;
        RDY_get = 1'b0;
        run_batch(32'h400, 400, cyc, fe, d1);
        RDY_get = 1'b1;
        total++; if (cyc != 262)       begin bad++; $display("FAIL to_latency got=%0d exp=262", cyc); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%b exp=1", timeout); end
        total++; if (pass !== 1'b0)    begin bad++; $display("FAIL to_pass got=%b exp=0", pass); end
        total++; if (en_get_n != 0)    begin bad++; $display("FAIL to_en_get_seen got=%0d exp=0", en_get_n); end
        total++; if (err_cnt !== 3'd0) begin bad++; $display("FAIL to_err_cnt got=%0d exp=0", err_cnt); end
        repeat (4) @(posedge clk);
        #1;
        total++; if (timeout !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL to_sticky timeout=%b done=%b exp=1/1", timeout, done); end
        run_batch(32'h50, 100, cyc, fe, d1);
        total++; if (timeout !== 1'b0 || pass !== 1'b1 || cyc != 13) begin
            bad++; $display("FAIL to_recover timeout=%b pass=%b cyc=%0d exp=0/1/13", timeout, pass, cyc);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; logic fe; logic d1;
        @(posedge clk); #1;
        base = 32'h40; start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (put_n == 2) break;
        end
        total++; if (put_n != 2 || busy !== 1'b1) begin bad++; $display("FAIL rst_mid_setup put_n=%0d busy=%b exp=2/1", put_n, busy); end
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0) begin
            bad++; $display("FAIL rst_mid_status busy=%b done=%b pass=%b timeout=%b exp=0", busy, done, pass, timeout);
        end
        total++; if (EN_put !== 1'b0 || EN_get !== 1'b0 || put_datas !== 32'h0 || err_cnt !== 3'd0) begin
            bad++; $display("FAIL rst_mid_outputs en_put=%b en_get=%b put_datas=%h err=%0d exp=0", EN_put, EN_get, put_datas, err_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        run_batch(32'h20, 100, cyc, fe, d1);
        total++; if (cyc != 13 || put_n != 6) begin bad++; $display("FAIL rst_mid_rerun cyc=%0d puts=%0d exp=13/6", cyc, put_n); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (put_log[i] !== 32'h20 + 32'(i)) begin
                bad++; $display("FAIL rst_mid_put_word[%0d] got=%h exp=%h", i, put_log[i], 32'h20 + 32'(i));
            end
        end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL rst_mid_pass got=%b exp=1", pass); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_mismatch();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
